// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//
// Command-driven AHB-Lite initiator. Single read/write commands from a local
// requester are turned into SINGLE/NONSEQ AHB-Lite transfers. The address
// phase of the next command overlaps the data phase of the current one, so
// back-to-back commands complete at one transfer per cycle when HREADY is high.
// Wait states freeze both phases. On a two-cycle ERROR response any pending
// address phase is withdrawn (HTRANS=IDLE) and reissued once the error ends.
//
// Ports
//   HCLK, HRESET           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (accepted when both high)
//   cmd_write/size/addr/wdata  command payload, sampled only on acceptance
//   rsp_valid              one-cycle pulse per completed data phase
//   rsp_write/error/rdata  completion info; rdata is HRDATA passthrough
//   HADDR..HWDATA          AHB-Lite master outputs
//   HRDATA, HREADY, HRESP  AHB-Lite slave-mux inputs
// ---------------------------------------------------------------------------
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Address-phase registers
    logic        a_valid_q, a_valid_d;
    logic [31:0] a_addr_q,  a_addr_d;
    logic        a_write_q, a_write_d;
    logic [2:0]  a_size_q,  a_size_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // Data-phase registers
    logic        d_valid_q, d_valid_d;
    logic        d_write_q, d_write_d;
    logic [31:0] d_wdata_q, d_wdata_d;

    // Set during the second cycle of an ERROR response: the first error cycle
    // was seen on the previous edge, so the pending address phase must stay
    // withdrawn for this cycle too.
    logic        err_q, err_d;

    logic        err_hold;
    logic        issue;
    logic        addr_done;
    logic        accept;

    // First cycle of an ERROR response (HRESP high, HREADY still low).
    assign err_hold  = d_valid_q && HRESP && !HREADY;
    assign issue     = a_valid_q && !err_hold && !err_q;
    assign addr_done = issue && HREADY;
    assign cmd_ready = !a_valid_q || addr_done;
    assign accept    = cmd_valid && cmd_ready;

    assign HTRANS    = issue ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HWDATA    = d_wdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = d_valid_q && HREADY;
    assign rsp_write = d_write_q;
    assign rsp_error = HRESP;
    assign rsp_rdata = HRDATA;

    always_comb begin
        a_valid_d = a_valid_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        d_valid_d = d_valid_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        err_d     = err_hold;

        // Address phase moves into the data phase; otherwise a completing
        // data phase empties the data-phase slot.
        if (addr_done) begin
            d_valid_d = 1'b1;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
        end else if (HREADY) begin
            d_valid_d = 1'b0;
        end

        // A newly accepted command takes the address slot; if the slot just
        // drained with nothing behind it, it goes empty.
        if (accept) begin
            a_valid_d = 1'b1;
            a_addr_d  = cmd_addr;
            a_write_d = cmd_write;
            a_size_d  = cmd_size;
            a_wdata_d = cmd_wdata;
        end else if (addr_done) begin
            a_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_write_q <= 1'b0;
            a_size_q  <= '0;
            a_wdata_q <= '0;
            d_valid_q <= 1'b0;
            d_write_q <= 1'b0;
            d_wdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            a_addr_q  <= a_addr_d;
            a_write_q <= a_write_d;
            a_size_q  <= a_size_d;
            a_wdata_q <= a_wdata_d;
            d_valid_q <= d_valid_d;
            d_write_q <= d_write_d;
            d_wdata_q <= d_wdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_tests;
    int n_fail;

    ahb_lite_master #(.HPROT_VALUE(4'b0011)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_error (rsp_error),
        .rsp_rdata (rsp_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance to 2 time units after the next rising edge; inputs are changed
    // there and outputs are sampled one unit later.
    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_size  = s;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        #1;
        n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
        n_tests++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
        n_tests++; if ({HWRITE, HSIZE} !== 4'h0) begin n_fail++; $display("FAIL rst_hwrite_hsize: got %h want 0", {HWRITE, HSIZE}); end
        n_tests++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        set_cmd(1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready: got %b want 1", cmd_ready); end
        tick();
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        n_tests++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL sw_htrans: got %h want 2", HTRANS); end
        n_tests++; if (HADDR !== 32'h10) begin n_fail++; $display("FAIL sw_haddr: got %h want 10", HADDR); end
        n_tests++; if ({HWRITE, HSIZE} !== 4'b1010) begin n_fail++; $display("FAIL sw_hwrite_hsize: got %b want 1010", {HWRITE, HSIZE}); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_early: got %b want 0", rsp_valid); end
        tick();
        #1;
        n_tests++; if (HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_hwdata: got %h want deadbeef", HWDATA); end
        n_tests++; if ({rsp_valid, rsp_write, rsp_error} !== 3'b110) begin n_fail++; $display("FAIL sw_rsp: got %b want 110", {rsp_valid, rsp_write, rsp_error}); end
        n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL sw_htrans_after: got %h want 0", HTRANS); end
        tick();
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] rdat  [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h33;
        // Cycle k: command k offered, address phase k-1, data phase k-2.
        for (int k = 0; k < 5; k++) begin
            if (k < 3) set_cmd(1'b1, 1'b0, 3'd2, addrs[k], 32'h0);
            else       set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            HRDATA = (k >= 2) ? rdat[k-2] : 32'h0;
            #1;
            if (k < 3) begin
                n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", k, cmd_ready); end
            end
            if (k >= 1 && k <= 3) begin
                n_tests++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL b2b_htrans%0d: got %h want 2", k, HTRANS); end
                n_tests++; if (HADDR !== addrs[k-1]) begin n_fail++; $display("FAIL b2b_haddr%0d: got %h want %h", k, HADDR, addrs[k-1]); end
            end
            if (k >= 2) begin
                n_tests++; if ({rsp_valid, rsp_write} !== 2'b10) begin n_fail++; $display("FAIL b2b_rsp%0d: got %b want 10", k, {rsp_valid, rsp_write}); end
                n_tests++; if (rsp_rdata !== rdat[k-2]) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", k, rsp_rdata, rdat[k-2]); end
            end else begin
                n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_idle%0d: got %b want 0", k, rsp_valid); end
            end
            tick();
        end
        HRDATA = 32'h0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin n_fail++; $display("FAIL b2b_drain: got rsp %b htrans %h want 0 0", rsp_valid, HTRANS); end
    endtask

    task automatic test_wait_states();
        set_cmd(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        tick();
        set_cmd(1'b1, 1'b1, 3'd0, 32'h25, 32'h0000_AB00);
        #1;
        n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h20) begin n_fail++; $display("FAIL ws_rd_addr: got %h/%h want 2/20", HTRANS, HADDR); end
        tick();
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        HREADY = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            n_tests++; if (HADDR !== 32'h25 || HSIZE !== 3'd0 || HWRITE !== 1'b1) begin n_fail++; $display("FAIL ws_hold%0d: got addr %h size %0d wr %b want 25 0 1", w, HADDR, HSIZE, HWRITE); end
            n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ws_ready%0d: got %b want 0", w, cmd_ready); end
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws_rsp%0d: got %b want 0", w, rsp_valid); end
            tick();
        end
        HREADY = 1'b1;
        HRDATA = 32'h5A5A_0001;
        #1;
        n_tests++; if ({rsp_valid, rsp_write, rsp_error} !== 3'b100) begin n_fail++; $display("FAIL ws_rd_rsp: got %b want 100", {rsp_valid, rsp_write, rsp_error}); end
        n_tests++; if (rsp_rdata !== 32'h5A5A_0001) begin n_fail++; $display("FAIL ws_rd_data: got %h want 5a5a0001", rsp_rdata); end
        n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h25) begin n_fail++; $display("FAIL ws_wr_addr: got %h/%h want 2/25", HTRANS, HADDR); end
        tick();
        HRDATA = 32'h0;
        #1;
        n_tests++; if ({rsp_valid, rsp_write} !== 2'b11) begin n_fail++; $display("FAIL ws_wr_rsp: got %b want 11", {rsp_valid, rsp_write}); end
        n_tests++; if (HWDATA !== 32'h0000_AB00) begin n_fail++; $display("FAIL ws_hwdata: got %h want 0000ab00", HWDATA); end
        tick();
    endtask

    task automatic test_error();
        set_cmd(1'b1, 1'b0, 3'd2, 32'h4000_0000, 32'h0);
        tick();
        set_cmd(1'b1, 1'b1, 3'd2, 32'h8, 32'h1234_5678);
        #1;
        n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h4000_0000) begin n_fail++; $display("FAIL err_rd_addr: got %h/%h want 2/40000000", HTRANS, HADDR); end
        tick();
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        HRESP = 1'b1; HREADY = 1'b0;
        #1;
        n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL err_c1_htrans: got %h want 0", HTRANS); end
        n_tests++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_c1_ctl: got ready %b rsp %b want 0 0", cmd_ready, rsp_valid); end
        tick();
        HREADY = 1'b1;
        #1;
        n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL err_c2_htrans: got %h want 0", HTRANS); end
        n_tests++; if ({rsp_valid, rsp_write, rsp_error} !== 3'b101) begin n_fail++; $display("FAIL err_c2_rsp: got %b want 101", {rsp_valid, rsp_write, rsp_error}); end
        n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL err_c2_ready: got %b want 0", cmd_ready); end
        tick();
        HRESP = 1'b0;
        #1;
        n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h8 || HWRITE !== 1'b1) begin n_fail++; $display("FAIL err_reissue: got %h/%h/%b want 2/8/1", HTRANS, HADDR, HWRITE); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_reissue_rsp: got %b want 0", rsp_valid); end
        tick();
        #1;
        n_tests++; if ({rsp_valid, rsp_write, rsp_error} !== 3'b110) begin n_fail++; $display("FAIL err_wr_rsp: got %b want 110", {rsp_valid, rsp_write, rsp_error}); end
        n_tests++; if (HWDATA !== 32'h1234_5678) begin n_fail++; $display("FAIL err_hwdata: got %h want 12345678", HWDATA); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_cmd(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        HREADY = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait_rsp: got %b want 0", rsp_valid); end
        HRESET = 1'b1;
        #1;
        n_tests++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin n_fail++; $display("FAIL rm_async: got %h/%h want 0/0", HTRANS, HADDR); end
        HREADY = 1'b1;
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_in_rst: got %b want 0", rsp_valid); end
        tick();
        HRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after%0d: got ready %b rsp %b want 1 0", c, cmd_ready, rsp_valid); end
            tick();
        end
    endtask

    task automatic test_idle();
        set_cmd(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_bus%0d: got htrans %h rsp %b want 0 0", c, HTRANS, rsp_valid); end
            n_tests++; if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011) begin n_fail++; $display("FAIL idle_const%0d: got burst %h lock %b prot %h want 0 0 3", c, HBURST, HMASTLOCK, HPROT); end
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
